// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock / reset sequencer: state encoding,
// simulation-scale cycle constants and the counter-width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLLRST    = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        INIT      = 3'd3,
        RUN       = 3'd4
    } seq_state_t;

    // Short timings so a simulation walks the whole sequence in a few hundred cycles.
    localparam int SIM_LOCK_STABLE_CYCLES  = 8;
    localparam int SIM_LOCK_TIMEOUT_CYCLES = 32;
    localparam int SIM_PLL_RST_CYCLES      = 4;
    localparam int SIM_INIT_TIMEOUT_CYCLES = 64;

    function automatic longint max_cycles(input longint a, input longint b,
                                          input longint c, input longint d);
        longint m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up and lock-loss reset sequencer: pulses the rPLL reset, qualifies LOCK,
// then releases the PSRAM controller and finally the system logic.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES  = 2700,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int INIT_TIMEOUT_CYCLES = 270000,
    parameter int CNT_W               = 20
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       psram_calib,
    output logic       pll_reset,
    output logic       psram_rst_n,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    if (max_cycles(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES, PLL_RST_CYCLES,
                   INIT_TIMEOUT_CYCLES) > (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the largest cycle parameter");
    end

    // Transitions fire on the last cycle of each interval, so compare against N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST      = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT_CYCLES - 1);

    seq_state_t       state_q;
    seq_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             calib_s;
    logic             pll_reset_next;
    logic             psram_rst_n_next;
    logic             sys_rst_n_next;
    logic             ready_next;

    sync_2ff u_sync_lock (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    sync_2ff u_sync_calib (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (psram_calib),
        .q     (calib_s)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PLLRST;
            cnt          <= '0;
            pll_reset    <= 1'b1;
            psram_rst_n  <= 1'b0;
            sys_rst_n    <= 1'b0;
            ready        <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            state_q     <= state_next;
            cnt         <= (state_next != state_q) ? '0 : cnt + 1'b1;
            pll_reset   <= pll_reset_next;
            psram_rst_n <= psram_rst_n_next;
            sys_rst_n   <= sys_rst_n_next;
            ready       <= ready_next;
            if (state_q == RUN && state_next == PLLRST && relock_count != 8'hFF) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

    // Lock loss is tested first everywhere, then completion, then timeout.
    always_comb begin
        state_next = state_q;
        case (state_q)
            PLLRST: begin
                if (cnt == PLL_RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                          state_next = STABLE;
                else if (cnt == LOCK_TIMEOUT_LAST)   state_next = PLLRST;
            end
            STABLE: begin
                if (!lock_s)                         state_next = WAIT_LOCK;
                else if (cnt == LOCK_STABLE_LAST)    state_next = INIT;
            end
            INIT: begin
                if (!lock_s)                         state_next = PLLRST;
                else if (calib_s)                    state_next = RUN;
                else if (cnt == INIT_TIMEOUT_LAST)   state_next = PLLRST;
            end
            RUN: begin
                if (!lock_s)                         state_next = PLLRST;
            end
            default: state_next = PLLRST;
        endcase
    end

    // Decoded from the next state so every reset output moves on the entering edge.
    always_comb begin
        pll_reset_next   = 1'b0;
        psram_rst_n_next = 1'b0;
        sys_rst_n_next   = 1'b0;
        ready_next       = 1'b0;
        case (state_next)
            PLLRST: pll_reset_next = 1'b1;
            INIT:   psram_rst_n_next = 1'b1;
            RUN: begin
                psram_rst_n_next = 1'b1;
                sys_rst_n_next   = 1'b1;
                ready_next       = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected output changes and their
// spacing in cycles are queued by the stimulus and checked by a negedge monitor.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       pr;
        logic       pm;
        logic       sr;
        logic       rdy;
        logic [7:0] rc;
        int         delta;
    } exp_t;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b1;
    logic       lock_ok = 1'b0;
    logic       calib_ok = 1'b0;
    logic       glitch = 1'b0;
    logic       pll_lock;
    logic       psram_calib;
    logic       pll_reset;
    logic       psram_rst_n;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] relock_count;
    logic [2:0] state;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    bit          armed = 1'b0;
    int          elapsed = 0;
    logic [14:0] last_vec;
    logic [14:0] cur;
    logic [14:0] want;

    always #5 clkin = ~clkin;

    // Plant: the PLL only reports lock while out of reset, and the PSRAM IP
    // only reports calibration once its reset is released.
    assign pll_lock    = lock_ok & ~glitch & ~pll_reset;
    assign psram_calib = calib_ok & psram_rst_n;

    pll_lock_sequencer #(
        .LOCK_STABLE_CYCLES  (SIM_LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES (SIM_LOCK_TIMEOUT_CYCLES),
        .PLL_RST_CYCLES      (SIM_PLL_RST_CYCLES),
        .INIT_TIMEOUT_CYCLES (SIM_INIT_TIMEOUT_CYCLES),
        .CNT_W               (20)
    ) dut (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .psram_calib  (psram_calib),
        .pll_reset    (pll_reset),
        .psram_rst_n  (psram_rst_n),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .relock_count (relock_count),
        .state        (state)
    );

    function automatic logic [14:0] outVec();
        return {state, pll_reset, psram_rst_n, sys_rst_n, ready, relock_count};
    endfunction

    // Monitor: every change of the output bundle consumes one expected record.
    always @(negedge clkin) begin
        if (!mon_en) begin
            armed = 1'b0;
        end else if (!armed) begin
            armed    = 1'b1;
            elapsed  = 0;
            last_vec = outVec();
        end else begin
            elapsed++;
            cur = outVec();
            if (cur !== last_vec) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_change: got outputs %h after %0d cycles, required no change",
                             cur, elapsed);
                end else begin
                    mon_e = exp_q.pop_front();
                    want  = {mon_e.st, mon_e.pr, mon_e.pm, mon_e.sr, mon_e.rdy, mon_e.rc};
                    if (cur !== want || elapsed != mon_e.delta) begin
                        fails++;
                        $display("[TB] FAIL %s: got state=%0d pll_reset=%b psram_rst_n=%b sys_rst_n=%b ready=%b relock=%0d after %0d cycles, required state=%0d pll_reset=%b psram_rst_n=%b sys_rst_n=%b ready=%b relock=%0d after %0d cycles",
                                 mon_e.name, cur[14:12], cur[11], cur[10], cur[9], cur[8], cur[7:0], elapsed,
                                 mon_e.st, mon_e.pr, mon_e.pm, mon_e.sr, mon_e.rdy, mon_e.rc, mon_e.delta);
                    end
                end
                last_vec = cur;
                elapsed  = 0;
            end
        end
    end

    task automatic pushExp(input string name, input logic [2:0] st, input logic pr,
                           input logic pm, input logic sr, input logic rdy,
                           input logic [7:0] rc, input int delta);
        exp_t e;
        e.name = name; e.st = st; e.pr = pr; e.pm = pm; e.sr = sr; e.rdy = rdy;
        e.rc = rc; e.delta = delta;
        exp_q.push_back(e);
    endtask

    // Expected bring-up after the PLL reset pulse, lock and calib following their resets.
    task automatic pushBringup(input string tag, input logic [7:0] rc);
        pushExp({tag, "_wait_lock"}, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, rc, 4);
        pushExp({tag, "_stable"},    STABLE,    1'b0, 1'b0, 1'b0, 1'b0, rc, 3);
        pushExp({tag, "_init"},      INIT,      1'b0, 1'b1, 1'b0, 1'b0, rc, 8);
        pushExp({tag, "_run"},       RUN,       1'b0, 1'b1, 1'b1, 1'b1, rc, 3);
    endtask

    task automatic applyStimulus(input logic lock, input logic calib);
        lock_ok  = lock;
        calib_ok = calib;
    endtask

    task automatic checkOutput(input string name, input logic [14:0] required);
        logic [14:0] got;
        got = outVec();
        tests++;
        if (got !== required) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, required);
        end
    endtask

    // Reset is asserted between clock edges and checked before the next edge.
    task automatic assertReset(input string name);
        @(posedge clkin);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput(name, {PLLRST, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        repeat (3) @(posedge clkin);
    endtask

    task automatic releaseReset();
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clkin);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got %0d events pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [7:0] rc;

        // Clean bring-up: ready first seen in cycle 19 after release.
        assertReset("reset_initial");
        applyStimulus(1'b1, 1'b1);
        pushBringup("bringup", 8'd0);
        releaseReset();
        waitDrain("bringup", 100);

        // Repeated lock loss in RUN; relock_count saturates.
        for (int i = 0; i < 300; i++) begin
            rc = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            pushExp("run_lock_loss", PLLRST, 1'b1, 1'b0, 1'b0, 1'b0, rc, 4);
            @(negedge clkin);
            lock_ok = 1'b0;
            waitDrain("run_lock_loss", 20);
            lock_ok = 1'b1;
            pushBringup("relock", rc);
            waitDrain("relock", 100);
        end

        // Lock never arrives: 4-cycle pll_reset pulses every 36 cycles.
        assertReset("reset_from_run");
        applyStimulus(1'b0, 1'b0);
        pushExp("timeout_wait_lock", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4);
        for (int k = 0; k < 3; k++) begin
            pushExp("timeout_pllrst",    PLLRST,    1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32);
            pushExp("timeout_wait_lock", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4);
        end
        releaseReset();
        waitDrain("lock_timeout", 200);

        // Three-cycle lock glitch inside STABLE restarts the stability count.
        assertReset("reset_from_wait");
        applyStimulus(1'b1, 1'b1);
        pushExp("glitch_wait_lock", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4);
        pushExp("glitch_stable",    STABLE,    1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3);
        releaseReset();
        waitDrain("glitch_enter", 50);
        repeat (4) @(negedge clkin);
        pushExp("glitch_back_to_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 7);
        pushExp("glitch_restable",     STABLE,    1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3);
        pushExp("glitch_init",         INIT,      1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8);
        pushExp("glitch_run",          RUN,       1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 3);
        glitch = 1'b1;
        repeat (3) @(negedge clkin);
        glitch = 1'b0;
        waitDrain("glitch", 100);

        // Calibration never completes: INIT lasts 64 cycles then restarts.
        assertReset("reset_from_run2");
        applyStimulus(1'b1, 1'b0);
        pushExp("calib_wait_lock", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4);
        pushExp("calib_stable",    STABLE,    1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3);
        pushExp("calib_init",      INIT,      1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8);
        pushExp("calib_timeout",   PLLRST,    1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 64);
        pushExp("calib_wait_lock", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4);
        pushExp("calib_stable",    STABLE,    1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3);
        pushExp("calib_init",      INIT,      1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8);
        releaseReset();
        waitDrain("calib_timeout", 300);

        // Asynchronous reset while sitting in INIT.
        repeat (5) @(posedge clkin);
        assertReset("reset_mid_init");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and lock-loss reset sequencer for the 81 MHz PSRAM clock domain. Runs on the free-running 27 MHz crystal clock, so it keeps working while the rPLL is unlocked. It drives the rPLL `RESET` input, watches `LOCK` for stability, and releases the PSRAM controller and then the system logic in order. If lock is lost or PSRAM calibration times out, it re-runs the whole sequence.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 2700: consecutive synchronized-lock cycles required before release (100 µs).
- `LOCK_TIMEOUT_CYCLES`, default 27000: maximum wait for lock before the PLL is reset again (1 ms).
- `PLL_RST_CYCLES`, default 16: width of the `pll_reset` pulse.
- `INIT_TIMEOUT_CYCLES`, default 270000: maximum wait for PSRAM calibration (10 ms).
- `CNT_W`, default 20: cycle counter width; it must hold the largest cycle parameter (elaboration-time check).

Ports:
- `clkin`, in, 1: 27 MHz crystal clock; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pll_lock`, in, 1: rPLL `LOCK`, asynchronous.
- `psram_calib`, in, 1: PSRAM IP calibration-done, asynchronous (81 MHz domain).
- `pll_reset`, out, 1: to rPLL `RESET`, active-high.
- `psram_rst_n`, out, 1: PSRAM IP reset, active-low.
- `sys_rst_n`, out, 1: cartridge logic reset, active-low.
- `ready`, out, 1: sequence complete.
- `relock_count`, out, 8: saturating count of lock losses seen while in RUN.
- `state`, out, 3: current state encoding, for debug.

## Operation
- `pll_lock` and `psram_calib` each pass through a 2-flop synchronizer, giving `lock_s` and `calib_s`.
- One shared cycle counter. It clears on every state transition and increments every cycle otherwise.
- States and transitions:
  - PLLRST (0): `pll_reset`=1. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
  - WAIT_LOCK (1):
    - If `lock_s`=1, go to STABLE.
    - Else, when the counter reaches `LOCK_TIMEOUT_CYCLES`, go to PLLRST.
  - STABLE (2):
    - If `lock_s`=0, go to WAIT_LOCK.
    - If `lock_s` has been high for `LOCK_STABLE_CYCLES` consecutive cycles, go to INIT.
  - INIT (3): `psram_rst_n`=1.
    - If `lock_s`=0, go to PLLRST.
    - Else if `calib_s`=1, go to RUN.
    - Else, when the counter reaches `INIT_TIMEOUT_CYCLES`, go to PLLRST.
  - RUN (4): `psram_rst_n`=1, `sys_rst_n`=1, `ready`=1.
    - If `lock_s`=0, go to PLLRST and increment `relock_count`, saturating at 255.
    - `calib_s` falling in RUN is ignored.
- Priority in every state: lock loss > completion condition > timeout.
- Output rule: all outputs are registered, decoded from the next state. Every reset output therefore asserts on the same edge that enters the new state.
- Reset behaviour (immediate, also mid-sequence):
  - state = PLLRST, counter = 0, `pll_reset`=1, `psram_rst_n`=0, `sys_rst_n`=0, `ready`=0, `relock_count`=0.
  - Synchronizer flops reset to 0.
- Downstream obligation: the 81 MHz consumers must synchronize the deassertion of `psram_rst_n` and `sys_rst_n` to their own clock.

## Timing
- Latency from `pll_lock` or `psram_calib` changing to a state change: 3 `clkin` edges (2 synchronizer edges plus 1 state register edge).
- `pll_reset` is high for exactly `PLL_RST_CYCLES` cycles per PLLRST visit.
- Minimum time from `rst_n` deassertion to `ready`, with lock and calibration already high: `PLL_RST_CYCLES` + 3 + `LOCK_STABLE_CYCLES` + 3 + 1 cycles.
- Release order: `psram_rst_n` goes high at least one cycle before `sys_rst_n`.
- On any exit from RUN or INIT, all three reset outputs assert in the same cycle. No ordering is required on assertion.
- Lock glitches:
  - A `pll_lock` glitch shorter than one `clkin` period may be missed; that is acceptable.
  - Any glitch that reaches `lock_s` restarts the stability count.

## Structure
- Package `pll_seq_pkg` holds:
  - The state enum: PLLRST=0, WAIT_LOCK=1, STABLE=2, INIT=3, RUN=4.
  - Simulation-scale default constants, used for the bench overrides.
- Sub-module `sync_2ff`: a single-bit 2-flop synchronizer with async active-low reset. It is instantiated twice.

## Test plan
Bench overrides: `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `PLL_RST_CYCLES`=4, `INIT_TIMEOUT_CYCLES`=64.
1. Clean bring-up.
   - Stimulus: release `rst_n`, hold `pll_lock`=1 and `psram_calib`=1.
   - Required: `pll_reset` high 4 cycles; `psram_rst_n` rises before `sys_rst_n`; `ready`=1 at cycle 4+3+8+3+1=19; `relock_count`=0.
2. Lock timeout.
   - Stimulus: hold `pll_lock`=0.
   - Required: `pll_reset` pulses 4 cycles wide, repeating every 36 cycles; `ready` stays 0.
3. Lock glitch during STABLE.
   - Stimulus: drop `pll_lock` for 3 cycles after 5 stable cycles.
   - Required: return to WAIT_LOCK; the stable count restarts; INIT is entered only after 8 fresh consecutive lock cycles.
4. Calibration timeout.
   - Stimulus: `pll_lock`=1, `psram_calib`=0.
   - Required: INIT lasts 64 cycles, then PLLRST; `psram_rst_n` returns to 0.
5. Lock loss in RUN, repeated 300 times.
   - Required: each loss asserts all resets and drops `ready` within 3 cycles; `relock_count` saturates at 255.
6. Mid-sequence reset.
   - Stimulus: assert `rst_n` during INIT.
   - Required: all outputs take reset values immediately, without waiting for a clock edge; `state`=0.
